// File: rtl/potts_latch_array_if.sv
// potts_latch_array_if
// Bundles the spin-array control, pulse, preload and snapshot handshake
// signals of potts_latch_array.
//   master : host / pulse front-end side (drives enable, pulse, cuts, load,
//            load_state, snap_req, snap_ready; observes state and snapshot)
//   slave  : the latch array itself
interface potts_latch_array_if #(
    parameter int N     = 144,
    parameter int CNT_W = 16
);
    logic             enable;
    logic [N-1:0]     pulse;
    logic [N:0]       cuts;
    logic             load;
    logic [N-1:0]     load_state;
    logic [N-1:0]     state;
    logic             snap_req;
    logic             snap_ready;
    logic             snap_valid;
    logic [N-1:0]     snap_state;
    logic [CNT_W-1:0] snap_flips;

    modport master (
        output enable, pulse, cuts, load, load_state, snap_req, snap_ready,
        input  state, snap_valid, snap_state, snap_flips
    );

    modport slave (
        input  enable, pulse, cuts, load, load_state, snap_req, snap_ready,
        output state, snap_valid, snap_state, snap_flips
    );
endinterface

// File: rtl/potts_latch_array.sv
// potts_latch_array
// Converts N SPAD pulse lines into N latched spin states. A cut map splits
// the chain into Potts domains (one-hot, winner-take-all through inhibition
// chains) or isolated Ising spins (toggle on each rise). Adds rising-edge
// pulse qualification, a state preload, a saturating flip counter and a
// snapshot readout handshake.
//
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous, active-high reset
//   bus  : potts_latch_array_if.slave
//          enable, pulse[N], cuts[N+1], load, load_state[N]  -> inputs
//          state[N]                                          -> latched spins
//          snap_req/snap_ready/snap_valid, snap_state, snap_flips -> readout
//
// Optional build macro: PULSE_SYNC_EN
//   defined     : two-flop synchroniser per pulse bit ahead of the edge
//                 detector (adds 2 edges of latency, for async SPAD lines)
//   not defined : pulse is sampled directly into the edge detector
module potts_latch_array #(
    parameter int N     = 144,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    potts_latch_array_if.slave   bus
);

    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        logic [CNT_W-1:0] r;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) r = CNT_MAX;
        else                     r = s[CNT_W-1:0];
        return r;
    endfunction

    logic [N-1:0]     pulse_in;
    logic [N-1:0]     pulse_p1, pulse_p2;
    logic [N-1:0]     rise;
    logic [N-1:0]     inc, dec, inhib;
    logic [N-1:0]     state_q, state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]  flips;
    logic             accept;
    logic             snap_valid_q;
    logic [N-1:0]     snap_state_q;
    logic [CNT_W-1:0] snap_flips_q;

    // ---- optional synchroniser stage ----
`ifdef PULSE_SYNC_EN
    logic [N-1:0] sync_p0, sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.pulse;
            sync_p1 <= sync_p0;
        end
    end

    assign pulse_in = sync_p1;
`else
    assign pulse_in = bus.pulse;
`endif

    // ---- edge-detect stage ----
    // Clearing p2 in reset means a pulse held through reset still yields
    // exactly one rise after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_p1 <= '0;
            pulse_p2 <= '0;
        end else begin
            pulse_p1 <= pulse_in;
            pulse_p2 <= pulse_p1;
        end
    end

    assign rise = pulse_p1 & ~pulse_p2;

    // ---- inhibition and spin update (combinational) ----
    // Inhibition ripples upward (inc) and downward (dec) from every rise and
    // stops at a cut. A running carry keeps each chain loop-free.
    always_comb begin
        logic carry;
        inc   = '0;
        dec   = '0;
        carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc[i] = carry;
            carry  = (carry | rise[i]) & ~bus.cuts[i+1];
        end
        carry = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            dec[i] = carry;
            carry  = (carry | rise[i]) & ~bus.cuts[i];
        end
    end

    assign inhib = inc | dec;

    // A spin's own rise outranks inhibition, so simultaneous rises in one
    // domain all end up set.
    always_comb begin
        state_next = state_q;
        if (bus.load) begin
            state_next = bus.load_state;
        end else if (bus.enable) begin
            for (int i = 0; i < N; i++) begin
                if (bus.cuts[i] & bus.cuts[i+1] & rise[i]) state_next[i] = ~state_q[i];
                else if (rise[i])                           state_next[i] = 1'b1;
                else if (inhib[i])                          state_next[i] = 1'b0;
            end
        end
    end

    assign flips  = (bus.enable && !bus.load) ? popcount(state_next ^ state_q) : '0;
    assign accept = bus.snap_req && (!snap_valid_q || bus.snap_ready);

    // ---- state, counter and snapshot registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= '0;
        else     state_q <= state_next;
    end

    // On accept the counter restarts with this cycle's flips so no flip is
    // lost between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            snap_valid_q <= 1'b0;
            snap_state_q <= '0;
            snap_flips_q <= '0;
        end else if (accept) begin
            cnt_q        <= sat_add('0, flips);
            snap_valid_q <= 1'b1;
            snap_state_q <= state_q;
            snap_flips_q <= cnt_q;
        end else begin
            cnt_q <= sat_add(cnt_q, flips);
            if (snap_valid_q && bus.snap_ready) snap_valid_q <= 1'b0;
        end
    end

    assign bus.state      = state_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.snap_state = snap_state_q;
    assign bus.snap_flips = snap_flips_q;

endmodule

// File: tb/tb_potts_latch_array.sv
// Testbench for potts_latch_array (N=8, CNT_W=4): a domain-level reference
// model predicts the outputs after every edge and queues them; a monitor pops
// and compares on each falling edge. Directed sequences add fixed-value checks.
module tb_potts_latch_array;
    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PULSE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    potts_latch_array_if #(.N(N), .CNT_W(CNT_W)) bus ();
    potts_latch_array #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0]     state;
        logic             sv;
        logic [N-1:0]     ss;
        logic [CNT_W-1:0] sf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [N-1:0]     m_state, m_p1, m_p2, m_s0, m_s1, m_ss;
    logic             m_sv;
    logic [CNT_W-1:0] m_sf;
    int               m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = '0; m_p1 = '0; m_p2 = '0; m_s0 = '0; m_s1 = '0;
        m_ss = '0; m_sv = 1'b0; m_sf = '0; m_cnt = 0;
    endtask

    // Predict the edge from the current inputs, advance one clock, queue it.
    task automatic tick();
        logic [N-1:0] rise, ns;
        exp_t e;
        int flips;
        bit acc;
        rise = m_p1 & ~m_p2;
        ns = m_state;
        if (bus.load) begin
            ns = bus.load_state;
        end else if (bus.enable) begin
            for (int i = 0; i < N; i++) begin
                int lo, hi;
                bit other;
                lo = i; hi = i; other = 0;
                while (lo > 0 && !bus.cuts[lo]) lo--;
                while (hi < N - 1 && !bus.cuts[hi+1]) hi++;
                for (int j = lo; j <= hi; j++) if (j != i && rise[j]) other = 1;
                if (bus.cuts[i] && bus.cuts[i+1] && rise[i]) ns[i] = ~m_state[i];
                else if (rise[i])                            ns[i] = 1'b1;
                else if (other)                              ns[i] = 1'b0;
            end
        end
        flips = (bus.load || !bus.enable) ? 0 : $countones(ns ^ m_state);
        acc = bus.snap_req && (!m_sv || bus.snap_ready);
        if (acc) begin
            m_ss  = m_state;
            m_sf  = CNT_W'(m_cnt);
            m_sv  = 1'b1;
            m_cnt = (flips > CMAX) ? CMAX : flips;
        end else begin
            if (m_sv && bus.snap_ready) m_sv = 1'b0;
            m_cnt = (m_cnt + flips > CMAX) ? CMAX : m_cnt + flips;
        end
`ifdef PULSE_SYNC_EN
        m_p2 = m_p1; m_p1 = m_s1; m_s1 = m_s0; m_s0 = bus.pulse;
`else
        m_p2 = m_p1; m_p1 = bus.pulse;
`endif
        m_state = ns;
        e.state = m_state; e.sv = m_sv; e.ss = m_ss; e.sf = m_sf;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic pulse_bit(input int b);
        bus.pulse = '0;
        bus.pulse[b] = 1'b1;
        tick();
        bus.pulse = '0;
        repeat (LAT - 1) tick();
    endtask

    // Monitor: compare DUT against queued prediction
    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            mon_e = q.pop_front();
            check("mon_state", 32'(bus.state), 32'(mon_e.state));
            check("mon_snap_valid", 32'(bus.snap_valid), 32'(mon_e.sv));
            check("mon_snap_state", 32'(bus.snap_state), 32'(mon_e.ss));
            check("mon_snap_flips", 32'(bus.snap_flips), 32'(mon_e.sf));
        end
    end

    initial begin
        int lat;
        int wait_cnt;
        rst = 1'b1;
        bus.enable = 1'b0; bus.pulse = '0; bus.cuts = '1; bus.load = 1'b0;
        bus.load_state = '0; bus.snap_req = 1'b0; bus.snap_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(bus.state), 32'h0);
        check("reset_snap_valid", 32'(bus.snap_valid), 32'h0);
        check("reset_snap_state", 32'(bus.snap_state), 32'h0);
        check("reset_snap_flips", 32'(bus.snap_flips), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Potts: single domain, winner-take-all
        bus.enable = 1'b1;
        bus.cuts = 9'b1_0000_0001;
        pulse_bit(3);
        check("potts_first", 32'(bus.state), 32'h08);
        pulse_bit(6);
        check("potts_second", 32'(bus.state), 32'h40);

        // Ising: held pulse toggles once, next rise toggles back
        bus.cuts = '1;
        bus.load = 1'b1; bus.load_state = '0; tick(); bus.load = 1'b0;
        bus.pulse = 8'h04;
        repeat (5) tick();
        bus.pulse = '0;
        repeat (LAT) tick();
        check("ising_held", 32'(bus.state), 32'h04);
        pulse_bit(2);
        check("ising_back", 32'(bus.state), 32'h00);

        // Cut boundary at spin 4
        bus.cuts = 9'b1_0001_0001;
        bus.load = 1'b1; bus.load_state = 8'hFF; tick(); bus.load = 1'b0;
        pulse_bit(1);
        check("cut_boundary", 32'(bus.state), 32'hF2);

        // Flip counter saturation and restart
        bus.cuts = '1;
        bus.snap_req = 1'b1; bus.snap_ready = 1'b1; tick();
        bus.snap_req = 1'b0; tick();
        check("snap_drop_valid", 32'(bus.snap_valid), 32'h0);
        bus.snap_ready = 1'b0;
        repeat (20) pulse_bit(0);
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        check("sat_flips", 32'(bus.snap_flips), 32'(CMAX));
        check("sat_valid", 32'(bus.snap_valid), 32'h1);
        bus.snap_ready = 1'b1; tick(); bus.snap_ready = 1'b0;
        repeat (2) pulse_bit(1);
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        check("restart_flips", 32'(bus.snap_flips), 32'h2);

        // Handshake: request while valid and not ready is dropped
        pulse_bit(5);
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        check("dropped_req_flips", 32'(bus.snap_flips), 32'h2);
        check("held_valid", 32'(bus.snap_valid), 32'h1);
        bus.snap_req = 1'b1; bus.snap_ready = 1'b1; tick();
        check("reaccept_flips", 32'(bus.snap_flips), 32'h1);
        check("reaccept_valid", 32'(bus.snap_valid), 32'h1);
        bus.snap_req = 1'b0; tick();
        bus.snap_ready = 1'b0;

        // Randomised operation against the model
        for (int k = 0; k < 400; k++) begin
            logic [N:0] c;
            c = (N + 1)'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                c[0] = 1'b1;
                c[N] = 1'b1;
            end
            bus.cuts       = c;
            bus.pulse      = N'($urandom);
            bus.enable     = ($urandom_range(0, 7) != 0);
            bus.load       = ($urandom_range(0, 15) == 0);
            bus.load_state = N'($urandom);
            bus.snap_req   = ($urandom_range(0, 3) == 0);
            bus.snap_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset mid-run with pulse held through reset
        bus.cuts = '1; bus.enable = 1'b1; bus.pulse = '0;
        bus.snap_req = 1'b0; bus.snap_ready = 1'b0;
        bus.load = 1'b1; bus.load_state = 8'hA5; tick(); bus.load = 1'b0;
        bus.snap_req = 1'b1; tick(); bus.snap_req = 1'b0;
        check("pre_reset_state", 32'(bus.state), 32'hA5);
        check("pre_reset_valid", 32'(bus.snap_valid), 32'h1);
        bus.pulse = 8'h01;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_state", 32'(bus.state), 32'h0);
        check("async_reset_valid", 32'(bus.snap_valid), 32'h0);
        check("async_reset_snap_state", 32'(bus.snap_state), 32'h0);
        check("async_reset_snap_flips", 32'(bus.snap_flips), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        lat = 0;
        while (lat < 10) begin
            tick();
            lat++;
            if (bus.state[0]) break;
        end
        check("post_reset_latency", 32'(lat), 32'(LAT));
        repeat (6) tick();
        check("held_pulse_one_rise", 32'(bus.state), 32'h01);
        bus.pulse = '0;

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 5) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/potts_latch_array.md
# potts_latch_array

Parametrised, reset-able successor to the VRSPAD Ising/Potts latch stage. It converts N SPAD pulse lines into N latched spin states, with a programmable cut map that splits the chain into Potts domains (one-hot, winner-take-all via inhibition chains) or isolated Ising spins (toggle). Over the single-stage design it adds:
- rising-edge pulse qualification
- a state preload
- a saturating flip counter
- a snapshot readout handshake

It sits between the SPAD pulse inputs and the annealer host readout logic.

## Interface
- N, 144, number of spins.
- CNT_W, 16, flip counter width.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  enables spin updates from pulses.
- pulse  in  N  raw SPAD pulse lines, level.
- cuts  in  N+1  cuts[i] separates spin i-1 from spin i; cuts[0], cuts[N] are end markers.
- load  in  1  overwrite state with load_state this cycle.
- load_state  in  N  preload value.
- state  out  N  latched spin states.
- snap_req  in  1  request snapshot.
- snap_ready  in  1  consumer accepts snapshot.
- snap_valid  out  1  snapshot held.
- snap_state  out  N  captured state.
- snap_flips  out  CNT_W  flips counted since the previous capture.

## Operation
- Reset values: state=0, flip counter=0, snap_valid=0, snap_state=0, snap_flips=0, pulse pipeline=0.
- Pulse path: p1 <= pulse (or the synchronised pulse, see Configuration); p2 <= p1; rise = p1 & ~p2. Only rise bits act, so a held pulse acts once.
- Inhibition, combinational from rise:
  - inc[0]=0; inc[i]=(inc[i-1]|rise[i-1]) & ~cuts[i].
  - dec[N-1]=0; dec[i]=(dec[i+1]|rise[i+1]) & ~cuts[i+1].
  - inhib[i]=inc[i]|dec[i].
- Per-spin priority, each cycle:
  - load: state<=load_state.
  - else if enable and cuts[i]&cuts[i+1]&rise[i] (Ising): state[i] toggles.
  - else if enable and rise[i]: state[i]<=1.
  - else if enable and inhib[i]: state[i]<=0.
  - else hold.
  - A spin with its own rise ignores inhibition. Simultaneous rises in one Potts domain all set to 1.
- Flip counter:
  - Each enabled, non-load cycle adds popcount(state_next ^ state) to the counter, saturating at 2^CNT_W-1.
  - Load cycles add nothing.
- Snapshot:
  - snap_req is accepted when snap_valid=0, or when snap_valid&snap_ready in the same cycle.
  - On accept, snap_state<=state (pre-edge value), snap_flips<=counter (pre-edge value), and snap_valid<=1.
  - In the accept cycle the counter restarts at that cycle's flip popcount, so flips in that cycle fall in the new window.
  - snap_valid&snap_ready without a request: snap_valid<=0.
  - A request while valid and not ready is dropped; the requester re-issues.
  - snap_state and snap_flips stay stable while snap_valid=1.
- enable=0: pulse pipeline still shifts, rises are discarded, and state holds.

## Timing
- Without the sync macro: pulse high at edge k gives p1=1 at k, and the state change is visible after edge k+1 (latency 2 edges from the pulse sample).
- With the sync macro: latency is 4 edges.
- Inhibition is same-cycle combinational over at most N-1 stages. The timing target assumes N ≤ 256 at 100 MHz.
- Snapshot: request at edge k gives snap_valid=1 after edge k.
- Reset asserted mid-operation clears everything asynchronously, including a pending snapshot. The first rise after reset deassertion needs p2=0, so a pulse held through reset registers as one rise.

## Configuration
- PULSE_SYNC_EN defined: a two-flop synchroniser per pulse bit sits before p1 (latency +2 edges). This is for SPAD lines that are asynchronous to clk.
- Not defined: pulse is sampled directly into p1.

## Test plan
- **Potts domain:** N=8, cuts=9'b1_0000_0001 (one domain), enable=1, pulse[3] rises → state=8'b0000_1000. Then pulse[6] rises alone → state=8'b0100_0000.
- **Ising:** cuts all 1, pulse[2] high for 5 cycles → state[2] toggles exactly once. A second rise toggles it back to 0.
- **Cut boundary:** cuts[4]=1 only interior cut, state preloaded 8'hFF, pulse[1] rises → state=8'hF2.
- **Flip counter saturation:** CNT_W=4, 20 isolated Ising toggles → snap_flips=15 on the next snapshot, and the counter restarts afterwards.
- **Snapshot handshake:** request with snap_ready=0 → snap_valid=1 and held. A second request is dropped. snap_ready=1 together with a request → new capture, snap_valid stays 1.
- **Reset mid-run:** assert rst while snap_valid=1 and state=8'hA5 → all outputs 0 immediately. With pulse held through reset, one rise is acted on after release. With PULSE_SYNC_EN defined, latency measures 4 edges.
